// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared types and helpers for the BPSK transmitter UART front end.
package bpsk_pkg;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} uart_rx_state_t;
    localparam int UART_DATA_BITS = 8;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: oversample tick, one clk pulse every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks.
module baud_tick_gen #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);
    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int CW  = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == CW'(DIV - 1);
    always_comb cnt_d = (restart || tick) ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 UART receiver with 3-sample majority vote and good-byte write strobe.
module uart_byte_receiver
    import bpsk_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] uart_byte,
    output logic                      write,
    output logic                      frame_error,
    output logic                      busy
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(UART_DATA_BITS);
    localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    uart_rx_state_t state_q, state_d;
    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic [SW-1:0] s_q;
    logic [NW-1:0] n_q;
    logic [UART_DATA_BITS-1:0] sh_q, byte_q;
    logic v0_q, v1_q, bit_q, write_q, ferr_q;
    logic tick, fall, mid, bend, vote, restart, write_d, ferr_d;

    assign fall    = rx_prev_q & ~rx_s_q;
    assign mid     = tick && s_q == S_HI;
    assign bend    = tick && s_q == S_END;
    assign vote    = maj3(v0_q, v1_q, rx_s_q);
    assign restart = state_q == RX_IDLE && fall;

    baud_tick_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk)
        if (!rst_n) state_q <= RX_IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  state_d = fall ? RX_START : RX_IDLE;
            RX_START: state_d = (mid && vote) ? RX_IDLE : bend ? RX_DATA : RX_START;
            RX_DATA:  state_d = (bend && n_q == NW'(UART_DATA_BITS - 1)) ? RX_STOP : RX_DATA;
            RX_STOP:  state_d = mid ? (vote ? RX_IDLE : RX_BREAK) : RX_STOP;
            RX_BREAK: state_d = (tick && rx_s_q) ? RX_IDLE : RX_BREAK;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Stop bit is judged at mid-bit so the next start edge is never missed.
    always_comb begin
        write_d = state_q == RX_STOP && mid && vote;
        ferr_d  = state_q == RX_STOP && mid && !vote;
        busy    = state_q != RX_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            s_q       <= '0;
            n_q       <= '0;
            sh_q      <= '0;
            byte_q    <= '0;
            v0_q      <= 1'b1;
            v1_q      <= 1'b1;
            bit_q     <= 1'b1;
            write_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            write_q   <= write_d;
            ferr_q    <= ferr_d;
            if (write_d) byte_q <= sh_q;
            if (state_q == RX_IDLE) s_q <= '0;
            else if (tick)          s_q <= (s_q == S_END) ? '0 : s_q + SW'(1);
            if (tick && s_q == S_LO)  v0_q  <= rx_s_q;
            if (tick && s_q == S_MID) v1_q  <= rx_s_q;
            if (mid)                  bit_q <= vote;
            if (state_q == RX_START && bend) n_q <= '0;
            if (state_q == RX_DATA && bend) begin
                sh_q <= {bit_q, sh_q[UART_DATA_BITS-1:1]};
                n_q  <= n_q + NW'(1);
            end
        end
    end

    assign uart_byte   = byte_q;
    assign write       = write_q;
    assign frame_error = ferr_q;
endmodule
